fetch: RTL and testbench
========================

// Module: fetch
// PURPOSE
//  Instruction-fetch stage; sits directly upstream of decode and drives its 16-bit instr input.
//  Owns the PC register and issues requests to instruction memory with a ready handshake.
//  Selects the next PC from PC+2 or a redirect target supplied by downstream branch/jump logic.
//  Handles HALT, misaligned-PC and memory-timeout conditions.
// PARAMETERS
//  RESET_PC   16'h0000  PC loaded on reset
//  WAIT_MAX   8         max consecutive not-ready cycles before err (>=1)
//  NOP_INSTR  16'h0800  instruction presented to decode when instr_valid=0
// PORTS
//  clk           in   1   single clock; all state updates on posedge
//  rst           in   1   synchronous, active-high reset
//  imem_req      out  1   fetch request, address on imem_addr
//  imem_addr     out  16  fetch address (= pc)
//  imem_data     in   16  instruction word, valid when imem_ready=1
//  imem_ready    in   1   memory has returned imem_data this cycle
//  redirect      in   1   taken branch/jump for the current valid instr
//  redirect_pc   in   16  redirect target
//  halt_in       in   1   decode control flags current instr as HALT
//  pc            out  16  address of the instruction now on instr
//  pc_plus2      out  16  pc + 2, mod 2^16 (link value / branch base)
//  instr         out  16  imem_data if instr_valid, else NOP_INSTR
//  instr_valid   out  1   instr is a real fetched instruction this cycle
//  halted        out  1   stage stopped (HALT or error); sticky until rst
//  err           out  1   misaligned PC or memory timeout; sticky until rst
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc<=RESET_PC, state<=RUN, wait_cnt<=0, halted<=0, err<=0.
//    While rst=1: imem_req=0, instr_valid=0. Outstanding request abandoned.
//  - States: RUN, WAIT, HALTED. Combinational outputs; zero added latency on imem_ready.
//  - RUN: if pc[0]=1 -> imem_req=0, next err<=1, halted<=1, ->HALTED. Else imem_req=1.
//      imem_ready=1 -> instr_valid=1; pc updates at edge (see next-PC). imem_ready=0 -> WAIT, wait_cnt<=1.
//  - WAIT: imem_req=1, same addr, pc held, instr_valid=0 unless imem_ready=1.
//      imem_ready=1 -> instr_valid=1, pc updates, wait_cnt<=0, ->RUN.
//      imem_ready=0 and wait_cnt==WAIT_MAX -> err<=1, halted<=1, ->HALTED; else wait_cnt++.
//  - Next-PC (only when instr_valid=1): halt_in -> pc held, halted<=1, ->HALTED;
//      else redirect -> redirect_pc; else pc_plus2. halt_in beats redirect.
//  - redirect/halt_in ignored when instr_valid=0.
//  - HALTED: imem_req=0, instr_valid=0, instr=NOP_INSTR, pc frozen; only rst exits.
//  - pc_plus2 wraps: pc=16'hFFFE -> 16'h0000. Odd redirect_pc loads, then faults in RUN.
//  - wait_cnt width $clog2(WAIT_MAX+1); never exceeds WAIT_MAX.
// STRUCTURE
//  - Shared package: state encodings (RUN/WAIT/HALTED), NOP opcode 16'h0800, default RESET_PC.
//  - One sub-module: fetch_pc_reg (16-bit sync-reset register, load enable, reset value param).
//  - FSM, wait counter, next-PC mux and sticky flags inline in fetch.
// TESTING
//  - Reset, imem_ready tied 1: pc 0000,0002,0004 on successive cycles; instr_valid=1 each cycle.
//  - imem_ready low 3 cycles at pc=0006: pc held, instr=0800, instr_valid=0; 4th cycle valid, pc->0008.
//  - redirect=1, redirect_pc=0040 at pc=0010: next pc=0040; same cycle with halt_in=1: pc stays 0010, halted=1.
//  - imem_ready held 0, WAIT_MAX=8: err=1 and halted=1 after 9th not-ready cycle; imem_req=0 thereafter.
//  - redirect_pc=0041: next cycle imem_req=0, err=1, halted=1; rst=1 one cycle -> pc=0000, flags clear.
//  - pc=FFFE valid fetch, no redirect: pc_plus2=0000, next pc=0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;
    localparam logic [15:0] RESET_PC_DEF  = 16'h0000;

endpackage : fetch_pkg

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface fetch_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_data,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_data,
        output imem_ready
    );
endinterface : fetch_if

// File: rtl/fetch_pc_reg.sv
// Program-counter register: synchronous reset to RST_VAL, loads d_i when load_i is high.
module fetch_pc_reg #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] pc_q;

    // PC storage with synchronous reset and load enable
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RST_VAL;
        end else if (load_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;
endmodule : fetch_pc_reg

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, requests imem, presents instr to decode.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | issuing a fetch at pc (faults immediately if pc is odd)
// ST_WAIT   | memory not ready yet; re-requesting same pc, counting stalls
// ST_HALTED | stopped by HALT or error; only rst leaves this state
module fetch
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
    parameter int          WAIT_MAX  = 8,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    fetch_if.master     imem,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    input  logic        halt_in_i,
    output logic [15:0] pc_o,
    output logic [15:0] pc_plus2_o,
    output logic [15:0] instr_o,
    output logic        instr_valid_o,
    output logic        halted_o,
    output logic        err_o
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            halted_q, halted_d;
    logic            err_q, err_d;
    logic            pc_load;
    logic [15:0]     pc_q, pc_d, pc_plus2;
    logic            req, valid;

    fetch_pc_reg #(
        .WIDTH   (16),
        .RST_VAL (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (pc_load),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

    assign pc_plus2 = pc_q + 16'd2;

    // Next-state, stall counter, next-PC selection and combinational outputs
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        halted_d   = halted_q;
        err_d      = err_q;
        pc_load    = 1'b0;
        pc_d       = pc_plus2;
        req        = 1'b0;
        valid      = 1'b0;

        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    if (pc_q[0]) begin
                        err_d    = 1'b1;
                        halted_d = 1'b1;
                        state_d  = ST_HALTED;
                    end else begin
                        req = 1'b1;
                        if (imem.imem_ready) begin
                            valid = 1'b1;
                        end else begin
                            wait_cnt_d = CW'(1);
                            state_d    = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    req = 1'b1;
                    if (imem.imem_ready) begin
                        valid      = 1'b1;
                        wait_cnt_d = '0;
                        state_d    = ST_RUN;
                    end else if (wait_cnt_q == CW'(WAIT_MAX)) begin
                        err_d    = 1'b1;
                        halted_d = 1'b1;
                        state_d  = ST_HALTED;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CW'(1);
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_HALTED;
                end
            endcase

            // HALT wins over redirect; both only matter on a real fetch
            if (valid) begin
                if (halt_in_i) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALTED;
                end else begin
                    pc_load = 1'b1;
                    pc_d    = redirect_i ? redirect_pc_i : pc_plus2;
                end
            end
        end
    end

    // FSM state, stall counter and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;
    assign pc_o           = pc_q;
    assign pc_plus2_o     = pc_plus2;
    assign instr_o        = valid ? imem.imem_data : NOP_INSTR;
    assign instr_valid_o  = valid;
    assign halted_o       = halted_q;
    assign err_o          = err_q;
endmodule : fetch

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage: directed vector table, hand sequences
// for the stall-timeout boundary, and randomized traffic against a reference model.
module tb_fetch;
    import fetch_pkg::*;

    localparam int WMAX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt_in;
    logic [15:0] pc, pc_plus2, instr;
    logic        instr_valid, halted, err;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fetch_if bus ();

    fetch #(
        .RESET_PC  (16'h0000),
        .WAIT_MAX  (WMAX),
        .NOP_INSTR (16'h0800)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (bus),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .halt_in_i     (halt_in),
        .pc_o          (pc),
        .pc_plus2_o    (pc_plus2),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .halted_o      (halted),
        .err_o         (err)
    );

    typedef struct {
        logic        r;
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic        hlt;
        logic        e_req;
        logic [15:0] e_pc;
        logic        e_vld;
        logic        e_halted;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic rdy, input logic redir,
                                input logic [15:0] rpc, input logic hlt,
                                input logic e_req, input logic [15:0] e_pc,
                                input logic e_vld, input logic e_halted, input logic e_err);
        vec_t v;
        v.r = r; v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.hlt = hlt;
        v.e_req = e_req; v.e_pc = e_pc; v.e_vld = e_vld;
        v.e_halted = e_halted; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic [15:0] d,
                         input logic redir, input logic [15:0] rpc, input logic hlt);
        rst             = r;
        bus.imem_ready  = rdy;
        bus.imem_data   = d;
        redirect        = redir;
        redirect_pc     = rpc;
        halt_in         = hlt;
    endtask

    // Compare every output against expectations; call at the negedge.
    task automatic chk_all(input string tag, input logic e_req, input logic [15:0] e_pc,
                           input logic e_vld, input logic e_halted, input logic e_err,
                           input logic [15:0] d);
        logic [15:0] e_instr;
        logic [15:0] e_pp2;
        e_instr = e_vld ? d : 16'h0800;
        e_pp2   = e_pc + 16'd2;
        chk({tag, " req"},      {15'd0, bus.imem_req}, {15'd0, e_req});
        chk({tag, " addr"},     bus.imem_addr,         e_pc);
        chk({tag, " pc"},       pc,                    e_pc);
        chk({tag, " pc_plus2"}, pc_plus2,              e_pp2);
        chk({tag, " valid"},    {15'd0, instr_valid},  {15'd0, e_vld});
        chk({tag, " instr"},    instr,                 e_instr);
        chk({tag, " halted"},   {15'd0, halted},       {15'd0, e_halted});
        chk({tag, " err"},      {15'd0, err},          {15'd0, e_err});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        next_cycle();
    endtask

    // Reference model: PC, consecutive not-ready count, sticky flags
    logic [15:0] m_pc;
    int          m_miss;
    logic        m_halt, m_err;

    initial begin
        logic [15:0] d;
        int          thr;
        int          idle;
        logic        r, rdy, redir, hlt, e_req, e_vld;
        logic [15:0] rpc;

        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // ---------------- directed table ----------------
        //            r  rdy red rpc       hlt req pc        vld hlt err
        tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0002, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0004, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 16'h0200, 1, 1, 16'h0006, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0006, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0006, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0006, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0008, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h000A, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h000C, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h000E, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 16'h0040, 0, 1, 16'h0010, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0040, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 16'h0080, 1, 1, 16'h0042, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0042, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0042, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 16'h0010, 0, 1, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 16'h0040, 1, 1, 16'h0010, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0010, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0010, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 16'h0041, 0, 1, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0041, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 16'h0041, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 16'h0041, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 16'hFFFE, 0, 1, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'hFFFE, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 16'h0000, 1, 0, 0));

        foreach (tbl[i]) begin
            d = 16'hA000 + 16'(i);
            drive(tbl[i].r, tbl[i].rdy, d, tbl[i].redir, tbl[i].rpc, tbl[i].hlt);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_pc, tbl[i].e_vld,
                    tbl[i].e_halted, tbl[i].e_err, d);
            next_cycle();
        end

        // ---------------- timeout: WAIT_MAX+1 not-ready cycles ----------------
        reset_cycle();
        for (int k = 1; k <= WMAX + 1; k++) begin
            drive(1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0);
            @(negedge clk);
            chk_all($sformatf("tmo%0d", k), 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234);
            next_cycle();
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0);
            @(negedge clk);
            chk_all($sformatf("tmo_after%0d", k), 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234);
            next_cycle();
        end

        // ---------------- WAIT_MAX not-ready cycles then ready: no error ----------------
        reset_cycle();
        for (int k = 1; k <= WMAX; k++) begin
            drive(1'b0, 1'b0, 16'h5678, 1'b0, 16'h0000, 1'b0);
            @(negedge clk);
            chk_all($sformatf("edge%0d", k), 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h5678);
            next_cycle();
        end
        drive(1'b0, 1'b1, 16'h5678, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        chk_all("edge_rdy", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h5678);
        next_cycle();
        drive(1'b0, 1'b1, 16'h9ABC, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        chk_all("edge_next", 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h9ABC);
        next_cycle();

        // ---------------- randomized traffic vs reference model ----------------
        reset_cycle();
        m_pc   = 16'h0000;
        m_miss = 0;
        m_halt = 1'b0;
        m_err  = 1'b0;
        idle   = 0;
        thr    = 90;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) begin
                case ((n / 250) % 4)
                    0: thr = 95;
                    1: thr = 60;
                    2: thr = 25;
                    default: thr = 4;
                endcase
            end
            idle  = m_halt ? idle + 1 : 0;
            r     = ($urandom_range(0, 99) == 0) || (idle > 3);
            rdy   = ($urandom_range(0, 99) < thr);
            redir = ($urandom_range(0, 4) == 0);
            rpc   = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 15) == 0) rpc[0] = 1'b1;
            if ($urandom_range(0, 7) == 0)  rpc = 16'hFFFE;
            hlt   = ($urandom_range(0, 39) == 0);
            d     = 16'($urandom);

            drive(r, rdy, d, redir, rpc, hlt);
            e_req = !r && !m_halt && !m_pc[0];
            e_vld = e_req && rdy;
            @(negedge clk);
            chk_all($sformatf("rnd%0d", n), e_req, m_pc, e_vld, m_halt, m_err, d);

            if (r) begin
                m_pc   = 16'h0000;
                m_miss = 0;
                m_halt = 1'b0;
                m_err  = 1'b0;
            end else if (!m_halt) begin
                if (m_pc[0]) begin
                    m_halt = 1'b1;
                    m_err  = 1'b1;
                end else if (rdy) begin
                    m_miss = 0;
                    if (hlt) m_halt = 1'b1;
                    else     m_pc   = redir ? rpc : m_pc + 16'd2;
                end else begin
                    m_miss++;
                    if (m_miss > WMAX) begin
                        m_halt = 1'b1;
                        m_err  = 1'b1;
                    end
                end
            end
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule : tb_fetch
